hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller. Generates flush_and_stall[1:0] for IF/ID, ID/EX, EX/MEM and MEM/WB
//  (bit0 = stall/hold, bit1 = flush/bubble), plus PC hold/redirect.
//  Covers load-use, taken branches resolved in MEM, and instruction/data bus wait states.
//  Tracks a stale in-flight fetch after a redirect, and keeps saturating stall/flush counters.
// PARAMETERS
//  CNT_WIDTH   32    width of perf counters stall_cnt / flush_cnt
//  TIMEOUT     1024  consecutive mem_busy cycles before mem_timeout sets
// PORTS
//  clk               in   1          clock
//  reset             in   1          asynchronous, active-high
//  id_rs1_addr       in   5          rs1 index of instruction in ID
//  id_rs2_addr       in   5          rs2 index of instruction in ID
//  id_uses_rs1       in   1          ID instruction reads rs1
//  id_uses_rs2       in   1          ID instruction reads rs2
//  ex_rd_addr        in   5          rd index held in ID/EX
//  ex_MemRead        in   1          ID/EX holds a load
//  mem_branch_taken  in   1          branch in EX/MEM resolved taken
//  if_busy           in   1          instruction fetch not yet complete this cycle
//  mem_busy          in   1          data access in MEM not yet complete this cycle
//  pc_hold           out  1          PC keeps its value
//  pc_redirect       out  1          PC loads branch target this edge
//  ifid_fs           out  2          flush_and_stall to IF/ID
//  idex_fs           out  2          flush_and_stall to ID/EX
//  exmem_fs          out  2          flush_and_stall to EX/MEM
//  memwb_fs          out  2          flush_and_stall to MEM/WB
//  stall_cnt         out  CNT_WIDTH  cycles with pc_hold=1 (saturating)
//  flush_cnt         out  CNT_WIDTH  cycles with pc_redirect=1 (saturating)
//  mem_timeout       out  1          sticky: mem_busy lasted >= TIMEOUT cycles
// BEHAVIOUR
//  - Control outputs combinational from inputs + state (0-cycle latency); never drive 2'b11.
//  - While reset=1: all fs = 2'b00, pc_hold=0, pc_redirect=0; state=RUN, counters=0, mem_timeout=0.
//  - load_use = ex_MemRead & ex_rd_addr!=0 & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)).
//  - Priority, highest first (only the first matching row applies):
//    1 mem_busy: pc_hold=1; ifid/idex/exmem=01; memwb=10; pc_redirect=0.
//    2 mem_branch_taken: pc_redirect=1; ifid/idex/exmem=10; memwb=00.
//      If if_busy=1 in this cycle, next state=SQUASH.
//    3 state==SQUASH: pc_hold=1; ifid=10; others 00. Return to RUN on the first cycle if_busy=0;
//      that cycle's fetched word is discarded by the flush.
//    4 load_use: pc_hold=1; ifid=01; idex=10; others 00.
//    5 if_busy: pc_hold=1; ifid=10; others 00 (bubble into ID, downstream drains).
//    6 otherwise: all 00, pc_hold=0.
//  - FSM states RUN, SQUASH. RUN->SQUASH only via row 2 with if_busy=1.
//  - In SQUASH, a new row-2 redirect keeps state SQUASH if if_busy=1, else ->RUN.
//  - mem_busy during SQUASH: row 1 outputs apply; state holds.
//  - Branch with load_use simultaneously: branch wins; the load-use victim is flushed.
//  - Branch with mem_busy: row 1 wins; EX/MEM held, so the branch re-presents once mem_busy drops.
//  - stall_cnt += 1 each cycle pc_hold=1; flush_cnt += 1 each cycle pc_redirect=1;
//    both saturate at all-ones, no wrap.
//  - busy_run counter: +1 per mem_busy cycle, cleared when mem_busy=0.
//    mem_timeout sets when busy_run reaches TIMEOUT-1 with mem_busy=1; cleared only by reset.
//  - Async reset mid-SQUASH returns to RUN immediately.
// TESTING
//  1 ex_MemRead=1, ex_rd=5, id_rs1=5, uses_rs1=1, 1 cycle -> pc_hold=1, ifid=01, idex=10; stall_cnt=1.
//  2 same as 1 with ex_rd=0 -> all 00, pc_hold=0, no stall.
//  3 mem_branch_taken=1 + load_use + if_busy=0 -> pc_redirect=1, ifid/idex/exmem=10; flush_cnt=1; state RUN.
//  4 mem_branch_taken=1 with if_busy=1, then if_busy=1 for 2 more cycles, then 0
//    -> 3 SQUASH-row cycles with ifid=10, pc_hold=1; RUN after the if_busy=0 cycle.
//  5 mem_busy=1 plus mem_branch_taken=1 for 3 cycles, then mem_busy=0
//    -> 3 cycles pc_hold=1, exmem=01, memwb=10; redirect fires on 4th cycle.
//  6 TIMEOUT=8, mem_busy held 8 cycles -> mem_timeout=1 after 8th edge, stays 1 after mem_busy=0;
//    reset -> 0; counters saturate when preloaded near max.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller producing per-stage flush_and_stall, PC hold/redirect and perf counters
module hazard_unit #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_MemRead,
  input  logic                 mem_branch_taken,
  input  logic                 if_busy,
  input  logic                 mem_busy,
  output logic                 pc_hold,
  output logic                 pc_redirect,
  output logic [1:0]           ifid_fs,
  output logic [1:0]           idex_fs,
  output logic [1:0]           exmem_fs,
  output logic [1:0]           memwb_fs,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout
);
  localparam int BW = $clog2(TIMEOUT + 1);
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [BW-1:0] busy_run_q, busy_run_d;
  logic timeout_q, timeout_d;
  logic load_use;
  assign load_use = ex_MemRead && ex_rd_addr != 5'd0 &&
                    ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
  always_comb begin
    pc_hold     = 1'b0;
    pc_redirect = 1'b0;
    ifid_fs     = 2'b00;
    idex_fs     = 2'b00;
    exmem_fs    = 2'b00;
    memwb_fs    = 2'b00;
    if (!reset) begin
      if (mem_busy) begin
        pc_hold  = 1'b1;
        ifid_fs  = 2'b01;
        idex_fs  = 2'b01;
        exmem_fs = 2'b01;
        memwb_fs = 2'b10;
      end else if (mem_branch_taken) begin
        pc_redirect = 1'b1;
        ifid_fs     = 2'b10;
        idex_fs     = 2'b10;
        exmem_fs    = 2'b10;
      end else if (state_q == SQUASH) begin
        pc_hold = 1'b1;
        ifid_fs = 2'b10;
      end else if (load_use) begin
        pc_hold = 1'b1;
        ifid_fs = 2'b01;
        idex_fs = 2'b10;
      end else if (if_busy) begin
        pc_hold = 1'b1;
        ifid_fs = 2'b10;
      end
    end
  end
  // A redirect or a pending squash stays in SQUASH until the stale fetch completes
  assign state_d     = mem_busy ? state_q :
                       ((mem_branch_taken || state_q == SQUASH) && if_busy) ? SQUASH : RUN;
  assign stall_cnt_d = stall_cnt_q + CNT_WIDTH'(pc_hold && !(&stall_cnt_q));
  assign flush_cnt_d = flush_cnt_q + CNT_WIDTH'(pc_redirect && !(&flush_cnt_q));
  assign busy_run_d  = !mem_busy ? '0 : (busy_run_q == BW'(TIMEOUT - 1)) ? busy_run_q : busy_run_q + 1'b1;
  assign timeout_d   = timeout_q || (mem_busy && busy_run_q == BW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      busy_run_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_run_q  <= busy_run_d;
      timeout_q   <= timeout_d;
    end
  end
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = timeout_q;
endmodule
